pc_fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the next-generation processor; replaces the fixed 10-bit PC register, PC+4 adder and branch/jump muxes.
- Owns the PC and issues one outstanding request to instruction memory over a valid/ready handshake, tolerating variable memory latency.
- Presents fetched instructions to decode with valid/ready backpressure.
- Accepts branch/jump redirects from execute and discards stale in-flight fetches.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_target_calc.sv | 37 +++
 rtl/pc_fetch_unit.sv | 121 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  localparam int INSTR_ALIGN    = 2;
  localparam int DEFAULT_DATA_W = 32;

endpackage

// File: rtl/fetch_target_calc.sv
// Combinational redirect detection and branch/jump target generation.
module fetch_target_calc
  import fetch_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic            branch,
  input  logic            zero,
  input  logic            jump,
  input  logic [31:0]     branch_imm,
  input  logic [25:0]     jump_index,
  input  logic [PC_W-1:0] redirect_base,
  output logic            redirect,
  output logic [PC_W-1:0] target
);

  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'((1 << INSTR_ALIGN) - 1);

  logic [31:0]     branch_off;
  logic [31:0]     base_ext;
  logic [31:0]     jump_full;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] jump_target;
  logic            unused_bits;

  assign branch_off    = branch_imm << INSTR_ALIGN;
  assign base_ext      = 32'(redirect_base);
  // Jump keeps the region bits of the base only when the PC is wider than 28 bits.
  assign jump_full     = {base_ext[31:28], jump_index, 2'b00};
  assign branch_target = redirect_base + branch_off[PC_W-1:0];
  assign jump_target   = jump_full[PC_W-1:0];

  assign redirect    = jump | (branch & zero);
  assign target      = (jump ? jump_target : branch_target) & ALIGN_MASK;
  assign unused_bits = ^{branch_off, base_ext, jump_full};

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one outstanding memory
// request at a time and hands fetched instructions to decode.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 10,
  parameter int              DATA_W   = DEFAULT_DATA_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc,
  output logic [PC_W-1:0]   inst_pc_plus4,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  input  logic [31:0]       branch_imm,
  input  logic [25:0]       jump_index,
  input  logic [PC_W-1:0]   redirect_base
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(1 << INSTR_ALIGN);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic            discard;
  logic            redirect;
  logic [PC_W-1:0] target;

  fetch_target_calc #(
    .PC_W(PC_W)
  ) u_target (
    .branch       (branch),
    .zero         (zero),
    .jump         (jump),
    .branch_imm   (branch_imm),
    .jump_index   (jump_index),
    .redirect_base(redirect_base),
    .redirect     (redirect),
    .target       (target)
  );

  assign imem_req_addr = pc;

  // discard marks an in-flight response that belongs to a fetch made before a redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      discard        <= 1'b0;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
      inst_data      <= '0;
      inst_pc        <= '0;
      inst_pc_plus4  <= PC_STEP;
    end else begin
      case (state)
        IDLE: begin
          state          <= REQ;
          imem_req_valid <= 1'b1;
        end
        REQ: begin
          if (redirect) pc <= target;
          if (imem_req_ready) begin
            state          <= WAIT;
            imem_req_valid <= 1'b0;
            if (redirect) discard <= 1'b1;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc <= target;
            if (imem_rsp_valid) begin
              discard        <= 1'b0;
              state          <= REQ;
              imem_req_valid <= 1'b1;
            end else begin
              discard <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (discard) begin
              discard        <= 1'b0;
              state          <= REQ;
              imem_req_valid <= 1'b1;
            end else begin
              inst_data     <= imem_rsp_data;
              inst_pc       <= pc;
              inst_pc_plus4 <= pc + PC_STEP;
              pc            <= pc + PC_STEP;
              inst_valid    <= 1'b1;
              state         <= HOLD;
            end
          end
        end
        HOLD: begin
          // A redirect drops the held instruction even if decode takes it this cycle.
          if (redirect || inst_ready) begin
            if (redirect) pc <= target;
            inst_valid     <= 1'b0;
            imem_req_valid <= 1'b1;
            state          <= REQ;
          end
        end
        default: begin
          state          <= IDLE;
          imem_req_valid <= 1'b0;
          inst_valid     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed phases push expected requests
// and instructions; negedge monitors pop and compare on each handshake.
module tb_pc_fetch_unit;

  localparam int PC_W   = 10;
  localparam int DATA_W = 32;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc4;
    logic [DATA_W-1:0] data;
  } exp_inst_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [PC_W-1:0]   imem_req_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [PC_W-1:0]   inst_pc;
  logic [PC_W-1:0]   inst_pc_plus4;
  logic              branch;
  logic              zero;
  logic              jump;
  logic [31:0]       branch_imm;
  logic [25:0]       jump_index;
  logic [PC_W-1:0]   redirect_base;
  logic              redir_in;

  int total = 0;
  int bad   = 0;

  logic [PC_W-1:0] req_q[$];
  exp_inst_t       inst_q[$];
  logic [PC_W-1:0] req_exp;
  exp_inst_t       inst_exp;

  int              mem_lat;
  int              mem_count;
  logic [PC_W-1:0] mem_addr;

  logic              req_prev_stall;
  logic [PC_W-1:0]   req_prev_addr;
  logic              inst_prev_hold;
  logic [PC_W-1:0]   inst_prev_pc;
  logic [DATA_W-1:0] inst_prev_data;

  assign redir_in = jump | (branch & zero);

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .PC_W    (PC_W),
    .DATA_W  (DATA_W),
    .RESET_PC(10'h000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_pc_plus4 (inst_pc_plus4),
    .branch        (branch),
    .zero          (zero),
    .jump          (jump),
    .branch_imm    (branch_imm),
    .jump_index    (jump_index),
    .redirect_base (redirect_base)
  );

  function automatic logic [DATA_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got timeout/unexpected event, required none", name);
  endtask

  task automatic push_req(input logic [PC_W-1:0] a);
    req_q.push_back(a);
  endtask

  task automatic push_inst(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] pc4);
    exp_inst_t e;
    e.pc   = pc;
    e.pc4  = pc4;
    e.data = mem_word(pc);
    inst_q.push_back(e);
  endtask

  // Run until both scoreboards empty, closing the memory once the last request is taken.
  task automatic drain(input string name);
    int n = 0;
    while ((req_q.size() != 0 || inst_q.size() != 0) && n < 80) begin
      @(posedge clk); #1;
      if (req_q.size() == 0) imem_req_ready = 1'b0;
      n++;
    end
    if (req_q.size() != 0 || inst_q.size() != 0) begin
      flag_fail(name);
      req_q.delete();
      inst_q.delete();
    end
    imem_req_ready = 1'b0;
  endtask

  task automatic wait_inst(input string name);
    int n = 0;
    while (n < 60) begin
      @(posedge clk); #1;
      if (req_q.size() == 0) imem_req_ready = 1'b0;
      if (inst_valid) break;
      n++;
    end
    if (!inst_valid) flag_fail(name);
    imem_req_ready = 1'b0;
  endtask

  task automatic apply_redirect(input logic b, input logic z, input logic j,
                                input logic [31:0] imm, input logic [25:0] idx,
                                input logic [PC_W-1:0] base);
    branch        = b;
    zero          = z;
    jump          = j;
    branch_imm    = imm;
    jump_index    = idx;
    redirect_base = base;
    @(posedge clk); #1;
    branch = 1'b0;
    zero   = 1'b0;
    jump   = 1'b0;
  endtask

  // Instruction memory: one outstanding request, response after mem_lat cycles.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mem_count      = 0;
    mem_addr       = '0;
    forever begin
      @(negedge clk);
      if (reset) mem_count = 0;
      else if (imem_req_valid && imem_req_ready) begin
        mem_addr  = imem_req_addr;
        mem_count = mem_lat;
      end
      @(posedge clk); #1;
      if (reset) begin
        mem_count      = 0;
        imem_rsp_valid = 1'b0;
      end else if (mem_count > 0) begin
        mem_count--;
        imem_rsp_valid = (mem_count == 0);
        imem_rsp_data  = mem_word(mem_addr);
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  initial begin
    req_prev_stall = 1'b0;
    req_prev_addr  = '0;
    forever begin
      @(negedge clk);
      if (reset) req_prev_stall = 1'b0;
      else begin
        if (req_prev_stall) begin
          check_output("req_stall_valid", imem_req_valid, 1);
          check_output("req_stall_addr", imem_req_addr, req_prev_addr);
        end
        if (imem_req_valid && imem_req_ready) begin
          if (req_q.size() == 0) flag_fail("req_unexpected");
          else begin
            req_exp = req_q.pop_front();
            check_output("req_addr", imem_req_addr, req_exp);
          end
        end
        req_prev_stall = imem_req_valid && !imem_req_ready && !redir_in;
        req_prev_addr  = imem_req_addr;
      end
    end
  end

  initial begin
    inst_prev_hold = 1'b0;
    inst_prev_pc   = '0;
    inst_prev_data = '0;
    forever begin
      @(negedge clk);
      if (reset) inst_prev_hold = 1'b0;
      else begin
        if (inst_prev_hold) begin
          check_output("inst_stall_valid", inst_valid, 1);
          check_output("inst_stall_pc", inst_pc, inst_prev_pc);
          check_output("inst_stall_data", inst_data, inst_prev_data);
        end
        if (inst_valid && inst_ready) begin
          if (inst_q.size() == 0) flag_fail("inst_unexpected");
          else begin
            inst_exp = inst_q.pop_front();
            check_output("inst_pc", inst_pc, inst_exp.pc);
            check_output("inst_pc_plus4", inst_pc_plus4, inst_exp.pc4);
            check_output("inst_data", inst_data, inst_exp.data);
          end
        end
        inst_prev_hold = inst_valid && !inst_ready && !redir_in;
        inst_prev_pc   = inst_pc;
        inst_prev_data = inst_data;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    branch         = 1'b0;
    zero           = 1'b0;
    jump           = 1'b0;
    branch_imm     = '0;
    jump_index     = '0;
    redirect_base  = '0;
    mem_lat        = 1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_req_valid", imem_req_valid, 0);
    check_output("reset_inst_valid", inst_valid, 0);
    check_output("reset_inst_data", inst_data, 0);
    check_output("reset_inst_pc", inst_pc, 0);

    // Sequential fetch from reset.
    push_req(10'h000); push_req(10'h004); push_req(10'h008);
    push_inst(10'h000, 10'h004); push_inst(10'h004, 10'h008); push_inst(10'h008, 10'h00C);
    reset = 1'b0;
    drain("seq_drain");

    // Stalled request redirected by a jump to 0x3FC, then wrap to 0x000.
    apply_redirect(1'b0, 1'b0, 1'b1, 32'h0, 26'h0FF, 10'h000);
    check_output("wrap_redirect_addr", imem_req_addr, 10'h3FC);
    check_output("wrap_redirect_valid", imem_req_valid, 1);
    push_req(10'h3FC); push_req(10'h000); push_req(10'h004);
    push_inst(10'h3FC, 10'h000); push_inst(10'h000, 10'h004); push_inst(10'h004, 10'h008);
    imem_req_ready = 1'b1;
    drain("wrap_drain");

    // Held instruction under backpressure, then dropped by a taken branch.
    inst_ready = 1'b0;
    push_req(10'h008);
    imem_req_ready = 1'b1;
    wait_inst("hold_wait");
    for (int i = 0; i < 5; i++) begin
      check_output("hold_no_req", imem_req_valid, 0);
      check_output("hold_valid", inst_valid, 1);
      check_output("hold_pc", inst_pc, 10'h008);
      check_output("hold_data", inst_data, 32'hA500_0008);
      @(posedge clk); #1;
    end
    apply_redirect(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'h0, 10'h010);
    check_output("branch_drop_valid", inst_valid, 0);
    check_output("branch_req_valid", imem_req_valid, 1);
    check_output("branch_req_addr", imem_req_addr, 10'h008);
    push_req(10'h008);
    push_inst(10'h008, 10'h00C);
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    drain("branch_drain");

    // Jump and taken branch together: jump target wins.
    apply_redirect(1'b1, 1'b1, 1'b1, 32'h0000_0001, 26'h040, 10'h020);
    check_output("jump_prio_addr", imem_req_addr, 10'h100);
    push_req(10'h100);
    push_inst(10'h100, 10'h104);
    imem_req_ready = 1'b1;
    drain("jump_drain");

    // Redirect while waiting on a 4-cycle memory: stale response must vanish.
    mem_lat = 4;
    push_req(10'h104);
    imem_req_ready = 1'b1;
    for (int n = 0; n < 20 && req_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    if (req_q.size() != 0) flag_fail("wait_accept");
    imem_req_ready = 1'b0;
    apply_redirect(1'b0, 1'b0, 1'b1, 32'h0, 26'h080, 10'h000);
    check_output("wait_redirect_no_inst", inst_valid, 0);
    check_output("wait_redirect_no_req", imem_req_valid, 0);
    push_req(10'h200);
    push_inst(10'h200, 10'h204);
    imem_req_ready = 1'b1;
    drain("wait_drain");

    // Asynchronous reset while an instruction is held.
    mem_lat    = 1;
    inst_ready = 1'b0;
    push_req(10'h204);
    imem_req_ready = 1'b1;
    wait_inst("reset_hold_wait");
    #2 reset = 1'b1;
    #1;
    check_output("async_reset_inst_valid", inst_valid, 0);
    check_output("async_reset_req_valid", imem_req_valid, 0);
    check_output("async_reset_inst_pc", inst_pc, 0);
    push_req(10'h000);
    push_inst(10'h000, 10'h004);
    inst_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    drain("post_reset_drain");
    check_output("final_req_valid", imem_req_valid, 1);
    check_output("final_req_addr", imem_req_addr, 10'h004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
